// File: rtl/mem_io_responder.sv
// Responder side of the CPU byte bus: a byte RAM plus an I/O window with tx/rx FIFOs,
// a free-running cycle counter with a coherent snapshot, and the tx back-pressure flag.
module mem_io_responder #(
    parameter int unsigned RAM_ADDR_W    = 17,
    parameter int unsigned TX_DEPTH_LOG2 = 4,
    parameter int unsigned RX_DEPTH_LOG2 = 4,
    parameter int unsigned FULL_MARGIN   = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_stop,
    output logic        tx_overflow
);

    localparam logic [TX_DEPTH_LOG2:0] TX_FULL = {1'b1, {TX_DEPTH_LOG2{1'b0}}};
    localparam logic [RX_DEPTH_LOG2:0] RX_FULL = {1'b1, {RX_DEPTH_LOG2{1'b0}}};

    logic [7:0] ram    [2**RAM_ADDR_W];
    logic [7:0] tx_mem [2**TX_DEPTH_LOG2];
    logic [7:0] rx_mem [2**RX_DEPTH_LOG2];

    logic [TX_DEPTH_LOG2:0] tx_wptr, tx_rptr, tx_count, tx_count_next, tx_free;
    logic [RX_DEPTH_LOG2:0] rx_wptr, rx_rptr, rx_count;
    logic [31:0]            counter, snapshot;

    logic       sel_io, sel_ram, rd, wr;
    logic [2:0] offset;
    logic       tx_push_req, tx_push, tx_pop, rx_push, rx_pop, ram_we;
    logic [7:0] tx_push_data, rd_data;

    always_comb begin
        sel_io  = (mem_a[17:16] == 2'b11);
        sel_ram = !sel_io && (mem_a[31:RAM_ADDR_W] == '0);
        rd      = rdy_in && !mem_wr;
        wr      = rdy_in && mem_wr;
        offset  = mem_a[2:0];
        ram_we  = wr && sel_ram;

        tx_count = tx_wptr - tx_rptr;
        rx_count = rx_wptr - rx_rptr;
        tx_valid = (tx_count != '0);
        tx_data  = tx_mem[tx_rptr[TX_DEPTH_LOG2-1:0]];
        rx_ready = (rx_count != RX_FULL);

        // Offset 4 is the stop marker: it always enqueues a 0x00 terminator byte.
        tx_push_req  = wr && sel_io && (((offset == 3'd0) && (mem_dout != 8'h00)) || (offset == 3'd4));
        tx_push_data = (offset == 3'd4) ? 8'h00 : mem_dout;
        tx_pop       = tx_valid && tx_ready;
        tx_push      = tx_push_req && ((tx_count != TX_FULL) || tx_pop);

        tx_count_next = tx_count + {{TX_DEPTH_LOG2{1'b0}}, tx_push}
                                 - {{TX_DEPTH_LOG2{1'b0}}, tx_pop};
        tx_free       = TX_FULL - tx_count_next;

        rx_push = rx_valid && rx_ready;
        rx_pop  = rd && sel_io && (offset == 3'd0) && (rx_count != '0);
    end

    always_comb begin
        rd_data = 8'h00;
        if (sel_io) begin
            case (offset)
                3'd0:    rd_data = (rx_count != '0) ? rx_mem[rx_rptr[RX_DEPTH_LOG2-1:0]] : 8'h00;
                3'd4:    rd_data = counter[7:0];
                3'd5:    rd_data = snapshot[15:8];
                3'd6:    rd_data = snapshot[23:16];
                3'd7:    rd_data = snapshot[31:24];
                default: rd_data = 8'h00;
            endcase
        end else if (sel_ram) begin
            rd_data = ram[mem_a[RAM_ADDR_W-1:0]];
        end
    end

    // Storage arrays carry no reset so they map onto plain memories.
    always_ff @(posedge clk_in) begin
        if (ram_we)
            ram[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
        if (tx_push)
            tx_mem[tx_wptr[TX_DEPTH_LOG2-1:0]] <= tx_push_data;
        if (rx_push)
            rx_mem[rx_wptr[RX_DEPTH_LOG2-1:0]] <= rx_data;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mem_din        <= 8'h00;
            tx_wptr        <= '0;
            tx_rptr        <= '0;
            rx_wptr        <= '0;
            rx_rptr        <= '0;
            counter        <= 32'h0;
            snapshot       <= 32'h0;
            io_buffer_full <= 1'b0;
            program_stop   <= 1'b0;
            tx_overflow    <= 1'b0;
        end else begin
            counter        <= counter + 32'd1;
            io_buffer_full <= (32'(tx_free) <= FULL_MARGIN);
            if (rd)
                mem_din <= rd_data;
            if (rd && sel_io && (offset == 3'd4))
                snapshot <= counter;
            if (wr && sel_io && (offset == 3'd4))
                program_stop <= 1'b1;
            if (tx_push_req && !tx_push)
                tx_overflow <= 1'b1;
            if (tx_push)
                tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)
                tx_rptr <= tx_rptr + 1'b1;
            if (rx_push)
                rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)
                rx_rptr <= rx_rptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: read results and tx bytes are queued as
// expectations when stimulus is driven and compared when the DUT presents them.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_stop;
    logic        tx_overflow;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  rd_exp_q[$];
    string       rd_tag_q[$];
    logic [7:0]  tx_exp_q[$];
    logic [31:0] cyc_m;

    mem_io_responder dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .mem_a(mem_a),
        .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .program_stop(program_stop), .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Reference cycle counter: value the DUT counter holds during the current cycle.
    always @(posedge clk_in or negedge rst_n_in)
        if (!rst_n_in) cyc_m <= 32'h0;
        else           cyc_m <= cyc_m + 32'd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        mem_a = a; mem_dout = d; mem_wr = 1'b1; rdy_in = 1'b1;
        tick();
        rdy_in = 1'b0; mem_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [7:0] e, input string tag);
        mem_a = a; mem_wr = 1'b0; rdy_in = 1'b1;
        rd_exp_q.push_back(e);
        rd_tag_q.push_back(tag);
        tick();
        rdy_in = 1'b0;
        chk(rd_tag_q.pop_front(), 32'(mem_din), 32'(rd_exp_q.pop_front()));
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic drain_tx(input string tag);
        int budget = 100;
        tx_ready = 1'b1;
        while (tx_exp_q.size() > 0 && budget > 0) begin
            if (tx_valid) chk(tag, 32'(tx_data), 32'(tx_exp_q.pop_front()));
            budget--;
            tick();
        end
        if (tx_exp_q.size() > 0) chk({tag, "_timeout"}, 32'(tx_exp_q.size()), 32'h0);
        tx_ready = 1'b0;
        chk({tag, "_empty"}, 32'(tx_valid), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b0; mem_a = 32'h0; mem_dout = 8'h0; mem_wr = 1'b0;
        tx_ready = 1'b0; rx_data = 8'h0; rx_valid = 1'b0;
        repeat (2) tick();
        rst_n_in = 1'b1;

        chk("rst_mem_din", 32'(mem_din), 32'h0);
        chk("rst_stop", 32'(program_stop), 32'h0);
        chk("rst_ovf", 32'(tx_overflow), 32'h0);
        chk("rst_full", 32'(io_buffer_full), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_rx_ready", 32'(rx_ready), 32'h1);

        // RAM round trip and an unmapped read
        bus_write(32'h0000_0123, 8'hA5);
        bus_read(32'h0000_0123, 8'hA5, "ram_rd");
        bus_read(32'h0002_4000, 8'h00, "unmapped_rd");

        // tx FIFO fill, near-full flag, overflow, zero-byte filter
        bus_write(32'h0003_0000, 8'h00);
        chk("tx_zero_ignored", 32'(tx_valid), 32'h0);
        for (int i = 0; i < 16; i++) begin
            bus_write(32'h0003_0000, 8'(8'h41 + i));
            tx_exp_q.push_back(8'(8'h41 + i));
            chk($sformatf("io_full_%0d", i + 1), 32'(io_buffer_full), (i >= 13) ? 32'h1 : 32'h0);
        end
        chk("ovf_before", 32'(tx_overflow), 32'h0);
        bus_write(32'h0003_0000, 8'h51);
        chk("ovf_after", 32'(tx_overflow), 32'h1);
        drain_tx("tx_fill");
        chk("full_after_drain", 32'(io_buffer_full), 32'h0);

        // rx FIFO reads, including empty
        rx_push(8'h31);
        rx_push(8'h32);
        chk("rx_ready_2", 32'(rx_ready), 32'h1);
        bus_read(32'h0003_0000, 8'h31, "rx_rd0");
        bus_read(32'h0003_0000, 8'h32, "rx_rd1");
        bus_read(32'h0003_0000, 8'h00, "rx_rd_empty");
        chk("rx_ready_end", 32'(rx_ready), 32'h1);

        // rdy_in low: no RAM write, no rx pop, mem_din held
        rx_push(8'h77);
        bus_read(32'h0000_0123, 8'hA5, "pre_stall_rd");
        mem_a = 32'h0000_0123; mem_dout = 8'h5A; mem_wr = 1'b1; rdy_in = 1'b0;
        tick();
        mem_a = 32'h0003_0000; mem_wr = 1'b0;
        tick();
        chk("stall_din_held", 32'(mem_din), 32'hA5);
        bus_read(32'h0000_0123, 8'hA5, "stall_ram_kept");
        bus_read(32'h0003_0000, 8'h77, "stall_rx_kept");

        // rx full boundary
        for (int i = 0; i < 16; i++) rx_push(8'(8'h60 + i));
        chk("rx_full_ready", 32'(rx_ready), 32'h0);
        bus_read(32'h0003_0000, 8'h60, "rx_full_head");
        chk("rx_ready_after_pop", 32'(rx_ready), 32'h1);

        // program_stop write and tx ordering
        chk("stop_before", 32'(program_stop), 32'h0);
        bus_write(32'h0003_0000, 8'h41);
        tx_exp_q.push_back(8'h41);
        bus_write(32'h0003_0004, 8'hEE);
        tx_exp_q.push_back(8'h00);
        chk("stop_after", 32'(program_stop), 32'h1);
        drain_tx("tx_stop");

        // asynchronous reset mid-run with a read in flight
        bus_write(32'h0003_0000, 8'h42);
        bus_read(32'h0000_0123, 8'hA5, "pre_rst_rd");
        chk("pre_rst_ovf", 32'(tx_overflow), 32'h1);
        mem_a = 32'h0000_0123; mem_wr = 1'b0; rdy_in = 1'b1;
        #2 rst_n_in = 1'b0;
        #1;
        chk("arst_mem_din", 32'(mem_din), 32'h0);
        chk("arst_stop", 32'(program_stop), 32'h0);
        chk("arst_ovf", 32'(tx_overflow), 32'h0);
        chk("arst_tx_valid", 32'(tx_valid), 32'h0);
        chk("arst_full", 32'(io_buffer_full), 32'h0);
        chk("arst_rx_ready", 32'(rx_ready), 32'h1);
        tick();
        chk("arst_din_hold", 32'(mem_din), 32'h0);
        rdy_in = 1'b0;
        rst_n_in = 1'b1;

        // counter snapshot coherence at 0x1FF
        for (int k = 0; k < 2000 && cyc_m != 32'h1FF; k++) tick();
        bus_read(32'h0003_0004, 8'hFF, "cnt_b0");
        repeat (3) tick();
        bus_read(32'h0003_0005, 8'h01, "snap_b1");
        bus_read(32'h0003_0006, 8'h00, "snap_b2");
        bus_read(32'h0003_0007, 8'h00, "snap_b3");
        bus_read(32'h0003_0004, cyc_m[7:0], "cnt_live");
        bus_read(32'h0003_0001, 8'h00, "io_off1");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
